// File: rtl/code_mem_arbiter.sv
// Two-port arbiter sharing one combinational code ROM between instruction fetch (IF)
// and MOVC reads (MV); fixed priority with a bounded starvation guard.
module code_mem_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 8,
   parameter int PRIO_MV    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_data,
   output logic          if_valid,
   input  logic          mv_req,
   input  logic [AW-1:0] mv_addr,
   output logic          mv_ack,
   output logic [DW-1:0] mv_data,
   output logic          mv_valid,
   output logic          rom_enable,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [0:0]    dbg_state
);

   // Handshake: a requester raises req with a stable addr and holds both until it
   // sees its one-cycle ack; the byte follows one cycle later with a one-cycle valid.
   // Requests are only sampled in IDLE, so ack and valid never coincide on a port.

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_READ = 1'b1;

   localparam logic       PRIO_IS_MV = (PRIO_MV != 0);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [0:0] state;
   logic       owner_mv;
   logic [3:0] starve_cnt;

   logic       conflict;
   logic       prio_req;
   logic       starve_hit;
   logic       grant_prio;
   logic       grant_mv;
   logic [3:0] cnt_next;

   always_comb begin
      conflict   = if_req & mv_req;
      prio_req   = PRIO_IS_MV ? mv_req : if_req;
      starve_hit = (STARVE_LIM != 4'd0) && (starve_cnt >= STARVE_LIM);
      grant_prio = conflict ? !starve_hit : prio_req;
      grant_mv   = PRIO_IS_MV ? grant_prio : !grant_prio;
      cnt_next   = starve_cnt;
      if (conflict) begin
         if (starve_hit)
            cnt_next = 4'd0;
         else if (starve_cnt != 4'd15)
            cnt_next = starve_cnt + 4'd1;
      end else if (!grant_prio) begin
         // Lone low-priority request: it was served, so it is no longer starving.
         cnt_next = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner_mv   <= 1'b0;
         starve_cnt <= 4'd0;
         rom_addr   <= '0;
         if_ack     <= 1'b0;
         mv_ack     <= 1'b0;
         if_valid   <= 1'b0;
         mv_valid   <= 1'b0;
         if_data    <= '0;
         mv_data    <= '0;
      end else begin
         if_ack   <= 1'b0;
         mv_ack   <= 1'b0;
         if_valid <= 1'b0;
         mv_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (if_req || mv_req) begin
                  state      <= ST_READ;
                  owner_mv   <= grant_mv;
                  rom_addr   <= grant_mv ? mv_addr : if_addr;
                  if_ack     <= !grant_mv;
                  mv_ack     <= grant_mv;
                  starve_cnt <= cnt_next;
               end
            end
            ST_READ: begin
               state <= ST_IDLE;
               if (owner_mv) begin
                  mv_data  <= rom_data;
                  mv_valid <= 1'b1;
               end else begin
                  if_data  <= rom_data;
                  if_valid <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rom_enable = (state == ST_READ);
   assign dbg_state  = state;

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Bench for code_mem_arbiter: main instance (MV priority, starvation limit 2) plus a
// pure fixed-priority instance sharing the same request stimulus.
module tb_code_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req, mv_req;
   logic [15:0] if_addr, mv_addr;

   logic        if_ack, if_valid, mv_ack, mv_valid, rom_enable;
   logic [7:0]  if_data, mv_data, rom_data;
   logic [15:0] rom_addr;
   logic [0:0]  dbg_state;

   logic        if_ack_b, if_valid_b, mv_ack_b, mv_valid_b, rom_enable_b;
   logic [7:0]  if_data_b, mv_data_b, rom_data_b;
   logic [15:0] rom_addr_b;
   logic [0:0]  dbg_state_b;

   int errors = 0;
   int checks = 0;

   logic [7:0] if_exp_q[$];
   logic [7:0] mv_exp_q[$];

   function automatic logic [7:0] rom_f(input logic [15:0] a);
      case (a)
         16'h0006: rom_f = 8'hF5;
         16'h0007: rom_f = 8'h91;
         16'h0008: rom_f = 8'h04;
         16'h00FD: rom_f = 8'h02;
         default:  rom_f = 8'h00;
      endcase
   endfunction

   assign rom_data   = rom_f(rom_addr);
   assign rom_data_b = rom_f(rom_addr_b);

   code_mem_arbiter #(.AW(16), .DW(8), .PRIO_MV(1), .STARVE_MAX(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_valid(if_valid),
      .mv_req(mv_req), .mv_addr(mv_addr), .mv_ack(mv_ack), .mv_data(mv_data), .mv_valid(mv_valid),
      .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
   );

   code_mem_arbiter #(.AW(16), .DW(8), .PRIO_MV(1), .STARVE_MAX(0)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_b), .if_data(if_data_b), .if_valid(if_valid_b),
      .mv_req(mv_req), .mv_addr(mv_addr), .mv_ack(mv_ack_b), .mv_data(mv_data_b), .mv_valid(mv_valid_b),
      .rom_enable(rom_enable_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .dbg_state(dbg_state_b)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard: every valid pops the port's expected queue
   always @(negedge clk) begin
      if (!rst) begin
         if (if_valid) begin
            checks++;
            if (if_exp_q.size() == 0) begin
               errors++;
               $display("FAIL if_data_unexpected: got %02h, no read outstanding", if_data);
            end else begin
               logic [7:0] e;
               e = if_exp_q.pop_front();
               if (if_data !== e) begin
                  errors++;
                  $display("FAIL if_data: got %02h expected %02h", if_data, e);
               end
            end
         end
         if (mv_valid) begin
            checks++;
            if (mv_exp_q.size() == 0) begin
               errors++;
               $display("FAIL mv_data_unexpected: got %02h, no read outstanding", mv_data);
            end else begin
               logic [7:0] e;
               e = mv_exp_q.pop_front();
               if (mv_data !== e) begin
                  errors++;
                  $display("FAIL mv_data: got %02h expected %02h", mv_data, e);
               end
            end
         end
         checks++;
         if ((if_ack && if_valid) || (mv_ack && mv_valid)) begin
            errors++;
            $display("FAIL ack_valid_overlap: if %b/%b mv %b/%b expected no overlap",
                     if_ack, if_valid, mv_ack, mv_valid);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 16'h0006; mv_req = 1'b0; mv_addr = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if_ack, mv_ack, if_valid, mv_valid, rom_enable, dbg_state} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {if_ack, mv_ack, if_valid, mv_valid, rom_enable, dbg_state});
      end
      checks++;
      if ({rom_addr, if_data, mv_data} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr %04h if %02h mv %02h expected all 0", rom_addr, if_data, mv_data);
      end
      if_req = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      if_req = 1'b1; if_addr = 16'h0006; if_exp_q.push_back(8'hF5);
      step();
      checks++;
      if ({if_ack, mv_ack, rom_enable, if_valid} !== 4'b1010 || rom_addr !== 16'h0006) begin
         errors++;
         $display("FAIL single_ack: ack/mvack/en/valid %b addr %04h expected 1010 0006",
                  {if_ack, mv_ack, rom_enable, if_valid}, rom_addr);
      end
      if_req = 1'b0;
      step();
      checks++;
      if ({if_valid, if_ack, rom_enable} !== 3'b100 || rom_addr !== 16'h0006) begin
         errors++;
         $display("FAIL single_valid: valid/ack/en %b addr %04h expected 100 0006",
                  {if_valid, if_ack, rom_enable}, rom_addr);
      end
      step();
      checks++;
      if (if_valid !== 1'b0 || if_ack !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: valid %b ack %b expected 0 0", if_valid, if_ack);
      end
   endtask

   task automatic test_conflict();
      if_req = 1'b1; if_addr = 16'h0007; mv_req = 1'b1; mv_addr = 16'h00FD;
      mv_exp_q.push_back(8'h02); if_exp_q.push_back(8'h91);
      step();
      checks++;
      if ({mv_ack, if_ack} !== 2'b10 || rom_addr !== 16'h00FD) begin
         errors++;
         $display("FAIL conflict_mv_first: mv/if ack %b addr %04h expected 10 00FD", {mv_ack, if_ack}, rom_addr);
      end
      mv_req = 1'b0;
      step();
      checks++;
      if (mv_valid !== 1'b1 || if_valid !== 1'b0 || if_data !== 8'hF5) begin
         errors++;
         $display("FAIL conflict_if_untouched: mvv %b ifv %b if_data %02h expected 1 0 F5",
                  mv_valid, if_valid, if_data);
      end
      step();
      checks++;
      if ({mv_ack, if_ack} !== 2'b01 || rom_addr !== 16'h0007) begin
         errors++;
         $display("FAIL conflict_if_second: mv/if ack %b addr %04h expected 01 0007", {mv_ack, if_ack}, rom_addr);
      end
      if_req = 1'b0;
      step();
      checks++;
      if (if_valid !== 1'b1 || mv_data !== 8'h02) begin
         errors++;
         $display("FAIL conflict_mv_untouched: ifv %b mv_data %02h expected 1 02", if_valid, mv_data);
      end
   endtask

   task automatic test_starvation();
      bit exp_mv[6];
      int cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (cnt < 2) begin exp_mv[i] = 1'b1; cnt++; end
         else begin exp_mv[i] = 1'b0; cnt = 0; end
         if (exp_mv[i]) mv_exp_q.push_back(8'h02);
         else           if_exp_q.push_back(8'h04);
      end
      if_req = 1'b1; if_addr = 16'h0008; mv_req = 1'b1; mv_addr = 16'h00FD;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if ({mv_ack, if_ack} !== {exp_mv[i], !exp_mv[i]}) begin
            errors++;
            $display("FAIL starve_grant%0d: mv/if ack %b expected %b", i, {mv_ack, if_ack}, {exp_mv[i], !exp_mv[i]});
         end
         step();
         checks++;
         if ({mv_valid, if_valid} !== {exp_mv[i], !exp_mv[i]}) begin
            errors++;
            $display("FAIL starve_valid%0d: mv/if valid %b expected %b", i, {mv_valid, if_valid}, {exp_mv[i], !exp_mv[i]});
         end
         if (i == 5) begin if_req = 1'b0; mv_req = 1'b0; end
      end
      step();
      checks++;
      if ({mv_ack, if_ack, rom_enable} !== 3'b000) begin
         errors++;
         $display("FAIL starve_idle: mv/if ack en %b expected 000", {mv_ack, if_ack, rom_enable});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs[3];
      addrs[0] = 16'h0006; addrs[1] = 16'h0007; addrs[2] = 16'h0008;
      if_exp_q.push_back(8'hF5); if_exp_q.push_back(8'h91); if_exp_q.push_back(8'h04);
      mv_addr = 16'h00FD;
      if_req = 1'b1; if_addr = addrs[0];
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({if_ack, mv_ack, if_valid} !== 3'b100 || rom_addr !== addrs[k]) begin
            errors++;
            $display("FAIL b2b_ack%0d: if/mv ack valid %b addr %04h expected 100 %04h",
                     k, {if_ack, mv_ack, if_valid}, rom_addr, addrs[k]);
         end
         if (k == 0) mv_req = 1'b1;
         if (k < 2) if_addr = addrs[k+1];
         else       if_req = 1'b0;
         step();
         checks++;
         if ({if_valid, if_ack, mv_ack, mv_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_valid%0d: ifv/ifa/mva/mvv %b expected 1000", k, {if_valid, if_ack, mv_ack, mv_valid});
         end
         mv_req = 1'b0;
      end
      step();
      checks++;
      if ({if_ack, if_valid, mv_ack} !== 3'b000) begin
         errors++;
         $display("FAIL b2b_idle: ifa/ifv/mva %b expected 000", {if_ack, if_valid, mv_ack});
      end
   endtask

   task automatic test_reset_in_read();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (mv_data !== 8'h00 || if_data !== 8'h00) begin
         errors++;
         $display("FAIL rr_pre: mv_data %02h if_data %02h expected 00 00", mv_data, if_data);
      end
      mv_req = 1'b1; mv_addr = 16'h00FD;
      step();
      checks++;
      if (mv_ack !== 1'b1 || rom_enable !== 1'b1) begin
         errors++;
         $display("FAIL rr_ack: mv_ack %b en %b expected 1 1", mv_ack, rom_enable);
      end
      rst = 1'b1; mv_req = 1'b0;
      step();
      checks++;
      if ({if_ack, mv_ack, if_valid, mv_valid, rom_enable, dbg_state} !== 6'b0 ||
          rom_addr !== 16'h0 || mv_data !== 8'h00) begin
         errors++;
         $display("FAIL rr_cleared: ctrl %b addr %04h mv_data %02h expected 000000 0000 00",
                  {if_ack, mv_ack, if_valid, mv_valid, rom_enable, dbg_state}, rom_addr, mv_data);
      end
      rst = 1'b0;
      step();
      checks++;
      if (mv_valid !== 1'b0 || mv_data !== 8'h00) begin
         errors++;
         $display("FAIL rr_no_valid: mv_valid %b mv_data %02h expected 0 00", mv_valid, mv_data);
      end
   endtask

   task automatic test_unmapped_and_pure_prio();
      bit exp_mv[4];
      int cnt = 0;
      if_req = 1'b1; if_addr = 16'h0006; if_exp_q.push_back(8'hF5);
      step();
      if_addr = 16'h1234; if_exp_q.push_back(8'h00);
      step();
      step();
      checks++;
      if (if_ack !== 1'b1 || rom_addr !== 16'h1234) begin
         errors++;
         $display("FAIL unmapped_ack: ack %b addr %04h expected 1 1234", if_ack, rom_addr);
      end
      if_req = 1'b0;
      step();
      checks++;
      if (if_valid !== 1'b1 || if_valid_b !== 1'b1 || if_data_b !== 8'h00) begin
         errors++;
         $display("FAIL unmapped_valid: v %b vb %b data_b %02h expected 1 1 00", if_valid, if_valid_b, if_data_b);
      end
      for (int i = 0; i < 4; i++) begin
         if (cnt < 2) begin exp_mv[i] = 1'b1; cnt++; end
         else begin exp_mv[i] = 1'b0; cnt = 0; end
         if (exp_mv[i]) mv_exp_q.push_back(8'h02);
         else           if_exp_q.push_back(8'h91);
      end
      if_req = 1'b1; if_addr = 16'h0007; mv_req = 1'b1; mv_addr = 16'h00FD;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({mv_ack_b, if_ack_b} !== 2'b10 || {mv_ack, if_ack} !== {exp_mv[i], !exp_mv[i]}) begin
            errors++;
            $display("FAIL pure_prio_grant%0d: b %b main %b expected 10 %b",
                     i, {mv_ack_b, if_ack_b}, {mv_ack, if_ack}, {exp_mv[i], !exp_mv[i]});
         end
         step();
         checks++;
         if (mv_valid_b !== 1'b1 || mv_data_b !== 8'h02 || if_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL pure_prio_valid%0d: mvv_b %b data_b %02h ifv_b %b expected 1 02 0",
                     i, mv_valid_b, mv_data_b, if_valid_b);
         end
         if (i == 3) begin if_req = 1'b0; mv_req = 1'b0; end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_conflict();
      test_starvation();
      test_back_to_back();
      test_reset_in_read();
      test_unmapped_and_pure_prio();
      repeat (2) step();
      checks++;
      if (if_exp_q.size() != 0 || mv_exp_q.size() != 0) begin
         errors++;
         $display("FAIL outstanding_reads: if %0d mv %0d expected 0 0", if_exp_q.size(), mv_exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
